// File: rtl/psr_pkg.sv
// Shared definitions for param_super_register: the 4-bit operation codes
// used by the RTL and by anything that drives the block.
package psr_pkg;

    typedef logic [3:0] mode_t;

    localparam mode_t MODE_HOLD = 4'b0000;
    localparam mode_t MODE_SHL  = 4'b0001;
    localparam mode_t MODE_SHR  = 4'b0010;
    localparam mode_t MODE_CLR  = 4'b0011;
    localparam mode_t MODE_SET  = 4'b0100;
    localparam mode_t MODE_UP   = 4'b0101;
    localparam mode_t MODE_DOWN = 4'b0110;
    localparam mode_t MODE_LOAD = 4'b0111;
    localparam mode_t MODE_ROTL = 4'b1000;
    localparam mode_t MODE_ROTR = 4'b1001;
    localparam mode_t MODE_ASHR = 4'b1010;
    localparam mode_t MODE_INV  = 4'b1011;

endpackage

// File: rtl/psr_counter.sv
// Combinational up/down step for the super register: next count value plus
// a flag that is raised whenever the step starts at the limit in its direction.
module psr_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             up,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] next,
    output logic             boundary
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        boundary = up ? (q == '1) : (q == '0);
        if (boundary && SATURATE) begin
            next = q;
        end else if (up) begin
            next = q + ONE;
        end else begin
            next = q - ONE;
        end
    end

endmodule

// File: rtl/param_super_register.sv
// Parameterised multi-mode register: shift, rotate, count, load and bitwise
// operations selected by mode, one result per rising clock edge.
module param_super_register
    import psr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] load,
    input  logic             lsi,
    input  logic             rsi,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             co
);

    logic [WIDTH-1:0] q_nxt;
    logic             so_nxt;
    logic             co_nxt;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_flag;

    psr_counter #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_counter (
        .up       (mode == MODE_UP),
        .q        (q),
        .next     (cnt_next),
        .boundary (cnt_flag)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        q_nxt  = q;
        so_nxt = so;
        co_nxt = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    q_nxt  = {q[WIDTH-2:0], lsi};
                    so_nxt = q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_nxt  = {rsi, q[WIDTH-1:1]};
                    so_nxt = q[0];
                end
                MODE_CLR:  q_nxt = '0;
                MODE_SET:  q_nxt = '1;
                MODE_UP, MODE_DOWN: begin
                    q_nxt  = cnt_next;
                    co_nxt = cnt_flag;
                end
                MODE_LOAD: q_nxt = load;
                MODE_ROTL: begin
                    q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
                    so_nxt = q[WIDTH-1];
                end
                MODE_ROTR: begin
                    q_nxt  = {q[0], q[WIDTH-1:1]};
                    so_nxt = q[0];
                end
                MODE_ASHR: begin
                    q_nxt  = {q[WIDTH-1], q[WIDTH-1:1]};
                    so_nxt = q[0];
                end
                MODE_INV:  q_nxt = ~q;
                default:   ;  // reserved codes behave as hold
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so q, so and co all update from the same pre-edge values.
        if (!rst_n) begin
            q  <= RESET_VAL;
            so <= 1'b0;
            co <= 1'b0;
        end else begin
            q  <= q_nxt;
            so <= so_nxt;
            co <= co_nxt;
        end
    end

endmodule

// File: tb/tb_param_super_register.sv
// Directed scoreboard bench: six instances (WIDTH 8/2/32, wrap and saturate)
// share one control stream; expectations are queued per step and checked after the edge.
module tb_param_super_register;
    import psr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, en, lsi, rsi;
    logic [3:0]  mode;
    logic [7:0]  load8;
    logic [1:0]  load2;
    logic [31:0] load32;

    logic [7:0]  q0, q1;
    logic [1:0]  q2, q3;
    logic [31:0] q4, q5;
    logic [5:0]  so_v, co_v;
    logic [31:0] obs_q [6];

    always #5 clk = ~clk;

    param_super_register #(.WIDTH(8), .RESET_VAL(8'h5A), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load8), .lsi(lsi), .rsi(rsi),
        .q(q0), .so(so_v[0]), .co(co_v[0]));
    param_super_register #(.WIDTH(8), .RESET_VAL(8'hA5), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load8), .lsi(lsi), .rsi(rsi),
        .q(q1), .so(so_v[1]), .co(co_v[1]));
    param_super_register #(.WIDTH(2), .RESET_VAL(2'b00), .SATURATE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load2), .lsi(lsi), .rsi(rsi),
        .q(q2), .so(so_v[2]), .co(co_v[2]));
    param_super_register #(.WIDTH(2), .RESET_VAL(2'b01), .SATURATE(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load2), .lsi(lsi), .rsi(rsi),
        .q(q3), .so(so_v[3]), .co(co_v[3]));
    param_super_register #(.WIDTH(32), .RESET_VAL(32'h0), .SATURATE(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load32), .lsi(lsi), .rsi(rsi),
        .q(q4), .so(so_v[4]), .co(co_v[4]));
    param_super_register #(.WIDTH(32), .RESET_VAL(32'hDEADBEEF), .SATURATE(1'b1)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load32), .lsi(lsi), .rsi(rsi),
        .q(q5), .so(so_v[5]), .co(co_v[5]));

    assign obs_q[0] = {24'd0, q0};
    assign obs_q[1] = {24'd0, q1};
    assign obs_q[2] = {30'd0, q2};
    assign obs_q[3] = {30'd0, q3};
    assign obs_q[4] = q4;
    assign obs_q[5] = q5;

    typedef struct {
        int          dut;
        string       tag;
        logic [31:0] q;
        logic        so;
        logic        co;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic drive(input logic [3:0] m, input logic e, input logic r,
                         input logic li, input logic ri);
        mode  = m;
        en    = e;
        rst_n = r;
        lsi   = li;
        rsi   = ri;
    endtask

    task automatic push(input int d, input string tag, input logic [31:0] qv,
                        input logic sov, input logic cov);
        exp_t e;
        e.dut = d; e.tag = tag; e.q = qv; e.so = sov; e.co = cov;
        sb.push_back(e);
    endtask

    // Same so for every instance, per-instance q and co.
    task automatic exp6(input string tag, input logic [31:0] a, b, c, d, e, f,
                        input logic [5:0] cov, input logic sov);
        push(0, tag, a, sov, cov[0]);
        push(1, tag, b, sov, cov[1]);
        push(2, tag, c, sov, cov[2]);
        push(3, tag, d, sov, cov[3]);
        push(4, tag, e, sov, cov[4]);
        push(5, tag, f, sov, cov[5]);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (obs_q[e.dut] === e.q) else begin
                n_fail++;
                $error("FAIL %s dut%0d q: observed %h expected %h", e.tag, e.dut, obs_q[e.dut], e.q);
            end
            n_assert++;
            assert (so_v[e.dut] === e.so) else begin
                n_fail++;
                $error("FAIL %s dut%0d so: observed %b expected %b", e.tag, e.dut, so_v[e.dut], e.so);
            end
            n_assert++;
            assert (co_v[e.dut] === e.co) else begin
                n_fail++;
                $error("FAIL %s dut%0d co: observed %b expected %b", e.tag, e.dut, co_v[e.dut], e.co);
            end
        end
    endtask

    // Shift/rotate/logic step: identical q for both saturate variants of a width, co always 0.
    task automatic op3(input logic [3:0] m, input logic li, input logic ri, input string tag,
                       input logic [31:0] q8, q2v, q32, input logic s8, s2, s32);
        drive(m, 1'b1, 1'b1, li, ri);
        push(0, tag, q8, s8, 1'b0);   push(1, tag, q8, s8, 1'b0);
        push(2, tag, q2v, s2, 1'b0);  push(3, tag, q2v, s2, 1'b0);
        push(4, tag, q32, s32, 1'b0); push(5, tag, q32, s32, 1'b0);
        tick();
    endtask

    task automatic ld(input logic [7:0] l8, input logic [1:0] l2, input logic [31:0] l32,
                      input logic sov);
        load8 = l8; load2 = l2; load32 = l32;
        drive(MODE_LOAD, 1'b1, 1'b1, 1'b0, 1'b0);
        exp6("load", l8, l8, l2, l2, l32, l32, 6'b000000, sov);
        tick();
    endtask

    initial begin
        load8 = '0; load2 = '0; load32 = '0;

        // Reset held for two edges with counting requested
        for (int i = 0; i < 2; i++) begin
            drive(MODE_UP, 1'b1, 1'b0, 1'b1, 1'b1);
            exp6("reset", 'h5A, 'hA5, 'h0, 'h1, 'h0, 'hDEADBEEF, 6'b000000, 1'b0);
            tick();
        end

        // First counts start from RESET_VAL
        drive(MODE_UP, 1'b1, 1'b1, 1'b0, 1'b0);
        exp6("cnt1", 'h5B, 'hA6, 'h1, 'h2, 'h1, 'hDEADBEF0, 6'b000000, 1'b0);
        tick();
        exp6("cnt2", 'h5C, 'hA7, 'h2, 'h3, 'h2, 'hDEADBEF1, 6'b000000, 1'b0);
        tick();
        exp6("cnt3", 'h5D, 'hA8, 'h3, 'h3, 'h3, 'hDEADBEF2, 6'b001000, 1'b0);
        tick();

        // Wrap versus saturate at all ones
        ld(8'hFE, 2'b10, 32'hFFFF_FFFE, 1'b0);
        drive(MODE_UP, 1'b1, 1'b1, 1'b0, 1'b0);
        exp6("wrap1", 'hFF, 'hFF, 'h3, 'h3, 'hFFFFFFFF, 'hFFFFFFFF, 6'b000000, 1'b0);
        tick();
        exp6("wrap2", 'h00, 'hFF, 'h0, 'h3, 'h0, 'hFFFFFFFF, 6'b111111, 1'b0);
        tick();
        exp6("wrap3", 'h01, 'hFF, 'h1, 'h3, 'h1, 'hFFFFFFFF, 6'b101010, 1'b0);
        tick();

        // Shift and rotate from MSB+LSB set
        ld(8'h81, 2'b11, 32'h8000_0001, 1'b0);
        op3(MODE_SHL,  1'b0, 1'b0, "shl",   'h02, 'h2, 'h2,        1'b1, 1'b1, 1'b1);
        op3(MODE_ROTR, 1'b0, 1'b0, "rotr1", 'h01, 'h1, 'h1,        1'b0, 1'b0, 1'b0);
        op3(MODE_ROTR, 1'b0, 1'b0, "rotr2", 'h80, 'h2, 'h80000000, 1'b1, 1'b1, 1'b1);
        op3(MODE_ASHR, 1'b0, 1'b1, "ashr",  'hC0, 'h3, 'hC0000000, 1'b0, 1'b0, 1'b0);

        // Remaining modes; so must hold through non-shifting ones
        op3(MODE_SHR,  1'b0, 1'b1, "shr1",  'hE0, 'h3, 'hE0000000, 1'b0, 1'b1, 1'b0);
        op3(MODE_ROTL, 1'b0, 1'b0, "rotl",  'hC1, 'h3, 'hC0000001, 1'b1, 1'b1, 1'b1);
        op3(MODE_INV,  1'b0, 1'b0, "inv",   'h3E, 'h0, 'h3FFFFFFE, 1'b1, 1'b1, 1'b1);
        op3(MODE_SET,  1'b0, 1'b0, "set",   'hFF, 'h3, 'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        op3(MODE_CLR,  1'b1, 1'b1, "clr",   'h00, 'h0, 'h0,        1'b1, 1'b1, 1'b1);
        op3(MODE_SHL,  1'b1, 1'b0, "shl1",  'h01, 'h1, 'h1,        1'b0, 1'b0, 1'b0);
        op3(MODE_HOLD, 1'b0, 1'b1, "hold",  'h01, 'h1, 'h1,        1'b0, 1'b0, 1'b0);
        op3(MODE_SHR,  1'b1, 1'b0, "shr0",  'h00, 'h0, 'h0,        1'b1, 1'b1, 1'b1);

        // Enable low and reserved codes hold everything
        ld(8'h3C, 2'b10, 32'h3C3C_3C3C, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive((i % 2 == 0) ? MODE_UP : MODE_SHL, 1'b0, 1'b1, 1'b1, 1'b1);
            exp6("en0", 'h3C, 'h3C, 'h2, 'h2, 'h3C3C3C3C, 'h3C3C3C3C, 6'b000000, 1'b1);
            tick();
        end
        drive(MODE_ROTR, 1'b0, 1'b1, 1'b0, 1'b0);
        exp6("en0rot", 'h3C, 'h3C, 'h2, 'h2, 'h3C3C3C3C, 'h3C3C3C3C, 6'b000000, 1'b1);
        tick();
        for (int i = 12; i < 16; i++) begin
            drive(4'(i), 1'b1, 1'b1, 1'b1, 1'b1);
            exp6("rsvd", 'h3C, 'h3C, 'h2, 'h2, 'h3C3C3C3C, 'h3C3C3C3C, 6'b000000, 1'b1);
            tick();
        end

        // Reset in the middle of a count-down
        ld(8'h02, 2'b10, 32'h2, 1'b1);
        drive(MODE_DOWN, 1'b1, 1'b1, 1'b0, 1'b0);
        exp6("dn1", 'h01, 'h01, 'h1, 'h1, 'h1, 'h1, 6'b000000, 1'b1);
        tick();
        drive(MODE_DOWN, 1'b1, 1'b0, 1'b0, 1'b0);
        exp6("midrst", 'h5A, 'hA5, 'h0, 'h1, 'h0, 'hDEADBEEF, 6'b000000, 1'b0);
        tick();
        drive(MODE_DOWN, 1'b1, 1'b1, 1'b0, 1'b0);
        exp6("dn2", 'h59, 'hA4, 'h3, 'h0, 'hFFFFFFFF, 'hDEADBEEE, 6'b010100, 1'b0);
        tick();
        exp6("dn3", 'h58, 'hA3, 'h2, 'h0, 'hFFFFFFFE, 'hDEADBEED, 6'b001000, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
